// File: rtl/mux_8way1bit_serializer_pkg.sv
// Shared types and constants for the 8-way 1-bit serializer.
package mux_serializer_pkg;

    localparam int FRAME_BITS = 8;
    localparam int SEL_W      = 3;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/mux_8way1bit_serializer_mux.sv
// Combinational 8:1 single-bit multiplexer; picks data_i[sel_i].
import mux_serializer_pkg::*;

module mux_8way1bit (
    input  logic [FRAME_BITS-1:0] data_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic                  bit_o
);

    // Pure select, no state.
    always_comb begin
        bit_o = data_i[sel_i];
    end

endmodule

// File: rtl/mux_8way1bit_serializer.sv
// 8-channel to 1-bit serializer: captures an 8-bit frame on load and
// shifts it out LSB channel first, one bit per clk, all outputs registered.
// Optional build macro PARITY_EN appends one even-parity bit to each frame.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready=1, out at OUT_IDLE; a load here captures a new frame
// SHIFT  | out = held[sel], sel walks 0..7
// PARITY | (PARITY_EN only) out = XOR of held bits, sel stays 7, done=1
import mux_serializer_pkg::*;

module mux_8way1bit_serializer #(
    parameter logic OUT_IDLE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] in,
    input  logic                  load,
    output logic                  ready,
    output logic                  out,
    output logic [SEL_W-1:0]      sel,
    output logic                  valid,
    output logic                  done
);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   held_q,  held_d;
    logic [SEL_W-1:0]        sel_q,   sel_d;
    logic                    out_q,   out_d;
    logic                    valid_q, valid_d;
    logic                    done_q,  done_d;
    logic                    ready_q, ready_d;
    logic                    par_d;
    logic                    mux_bit;

    // Select the bit that will be on out next cycle, so out stays a register.
    mux_8way1bit u_mux (
        .data_i (held_d),
        .sel_i  (sel_d),
        .bit_o  (mux_bit)
    );

    // Next-state, next-held-frame and next-output control decode.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        sel_d   = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
        par_d   = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (load) begin
                    held_d  = in;
                    sel_d   = '0;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (sel_q == SEL_LAST) begin
`ifdef PARITY_EN
                    state_d = PARITY;
                    sel_d   = sel_q;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    par_d   = 1'b1;
`else
                    state_d = IDLE;
                    ready_d = 1'b1;
`endif
                end else begin
                    state_d = SHIFT;
                    sel_d   = sel_q + 1'b1;
                    valid_d = 1'b1;
`ifndef PARITY_EN
                    // Without a parity bit the last data bit closes the frame.
                    done_d  = (sel_d == SEL_LAST);
`endif
                end
            end

`ifdef PARITY_EN
            PARITY: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
`endif

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Next serial bit: idle level, data bit from the mux, or the parity bit.
    always_comb begin
        out_d = OUT_IDLE;
        if (valid_d) begin
            out_d = par_d ? ^held_q : mux_bit;
        end
    end

    // State and output registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            held_q  <= '0;
            sel_q   <= '0;
            out_q   <= OUT_IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign out   = out_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign done  = done_q;

endmodule

// File: doc/mux_8way1bit_serializer.md
MUX_8WAY1BIT_SERIALIZER -- requirements
Module: mux_8way1bit_serializer

Interface
REQ-001 Parameter: OUT_IDLE, 1'b0, level driven on out when no frame is active.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: in  in  8  parallel frame; in[k] is channel k.
REQ-005 Port: load  in  1  request to capture in; accepted only when ready=1.
REQ-006 Port: ready  out  1  high when idle and able to accept load.
REQ-007 Port: out  out  1  serial bit stream.
REQ-008 Port: sel  out  3  index of channel currently on out.
REQ-009 Port: valid  out  1  out carries a frame bit (or parity bit).
REQ-010 Port: done  out  1  one-cycle pulse coincident with final bit of frame.

Function
REQ-011 The block SHALL be a registered FSM with states IDLE, SHIFT, PARITY (PARITY present only per REQ-024).
REQ-012 IDLE: ready=1, valid=0, done=0, sel=0, out=OUT_IDLE.
REQ-013 load=1 sampled with ready=1 at edge N SHALL capture in into an 8-bit holding register and enter SHIFT with sel=0.
REQ-014 Latency: channel 0 SHALL appear on out with valid=1 in the cycle after edge N (one-cycle load-to-first-bit latency).
REQ-015 SHIFT: out SHALL equal held[sel]; sel SHALL increment by 1 each cycle, 0 to 7, LSB channel first.
REQ-016 Frame SHALL occupy exactly 8 consecutive valid cycles (9 with parity); valid SHALL not drop mid-frame.
REQ-017 done SHALL be 1 only in the final valid cycle of a frame (sel=7 without parity; PARITY cycle with parity).
REQ-018 After the final valid cycle the FSM SHALL return to IDLE; ready SHALL rise the following cycle, giving exactly one idle cycle between back-to-back frames.
REQ-019 ready SHALL be 0 in SHIFT and PARITY; load while ready=0 SHALL be ignored and SHALL NOT alter the held frame.
REQ-020 Changes on in after capture SHALL NOT affect the frame in flight.
REQ-021 sel SHALL NOT wrap past 7 within a frame; the 7->0 transition occurs only through IDLE.
REQ-022 out, valid, sel, done, ready SHALL all be registered (no combinational path from load/in to outputs).

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) force IDLE: out=OUT_IDLE, valid=0, done=0, sel=0, ready=1, held register=0; a frame in progress SHALL be discarded with no done pulse; operation resumes on the first clk edge after rst_n rises.

Configuration
REQ-024 With PARITY_EN defined: after sel=7, one PARITY cycle SHALL drive out = XOR of the 8 held bits (even parity), valid=1, done=1, sel holding 7; without PARITY_EN: PARITY state and logic absent, done asserted at sel=7.

Structure
REQ-025 Package mux_serializer_pkg SHALL hold the state enum (IDLE, SHIFT, PARITY), FRAME_BITS=8, SEL_W=3.
REQ-026 Bit selection SHALL use sub-module mux_8way1bit (combinational 8:1 mux, inputs held[7:0], select sel); all sequencing stays in the top level.

Verification
REQ-027 Reset then load=1, in=8'b1010_0110 -> out sequence 0,1,1,0,0,1,0,1 with sel 0..7, valid high 8 cycles, done only at sel=7, ready back high 1 cycle later.
REQ-028 load held high continuously with in=8'hFF then 8'h00 -> frames of all-ones then all-zeros separated by exactly one cycle with valid=0, out=OUT_IDLE.
REQ-029 Mid-frame (sel=3) load=1 with in=8'h00 -> ignored; remaining bits match original frame; in toggled randomly after capture has no effect.
REQ-030 rst_n pulled low at sel=5 -> out=OUT_IDLE, valid=0, sel=0, ready=1 without clock edge; no done pulse; next load serialises correctly.
REQ-031 PARITY_EN defined, in=8'b0000_0111 -> 8 data bits then out=1, valid=1, done=1 in 9th cycle; in=8'h03 -> parity bit 0.
